// File: rtl/keccak_stream_absorber.sv
// keccak_stream_absorber: byte-keep stream absorber with straddle carry-over and multi-rate padding for a Keccak core
module keccak_stream_absorber #(
  parameter int DWIDTH = 256,
  parameter int KEEP_W = DWIDTH / 8,
  parameter int MAX_RATE = 1344
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [10:0]       rate_i,
  input  logic [7:0]        suffix_i,
  input  logic [DWIDTH-1:0] t_data_i,
  input  logic [KEEP_W-1:0] t_keep_i,
  input  logic              t_last_i,
  input  logic              t_valid_i,
  output logic              t_ready_o,
  output logic [1599:0]     state_o,
  output logic              perm_start_o,
  input  logic              perm_done_i,
  input  logic [1599:0]     perm_state_i,
  output logic              absorb_done_o
);
  localparam int CW = $clog2(MAX_RATE / 8 + 1);
  localparam int NW = $clog2(KEEP_W + 1);
  typedef enum logic [2:0] {S_IDLE, S_ABSORB, S_PERM_REQ, S_PERM_WAIT, S_CARRY, S_PAD, S_DONE} state_t;
  state_t r_fsm, w_fsm_nx;
  logic [1599:0] r_state;
  logic [CW-1:0] r_cnt, r_rate_b;
  logic [7:0] r_suffix;
  logic [DWIDTH-1:0] r_carry_data;
  logic [KEEP_W-1:0] r_carry_keep;
  logic r_carry_pend, r_pad_pend, r_padded;
  logic w_beat, w_fill;
  logic [DWIDTH-1:0] w_src_data, w_kdata, w_src_masked;
  logic [KEEP_W-1:0] w_src_keep;
  logic [NW-1:0] w_n;
  logic [CW-1:0] w_room;
  logic [1599:0] w_ins, w_pad;
  assign t_ready_o = (r_fsm == S_ABSORB) && !r_carry_pend;
  assign perm_start_o = r_fsm == S_PERM_REQ;
  assign absorb_done_o = r_fsm == S_DONE;
  assign state_o = r_state;
  assign w_beat = t_valid_i && t_ready_o;
  assign w_src_data = (r_fsm == S_CARRY) ? r_carry_data : t_data_i;
  assign w_src_keep = (r_fsm == S_CARRY) ? r_carry_keep : t_keep_i;
  assign w_n = NW'($countones(w_src_keep));
  assign w_room = r_rate_b - r_cnt;
  assign w_fill = CW'(w_n) >= w_room;
  assign w_ins = 1600'(w_src_masked) << {r_cnt, 3'b0};
  assign w_pad = (1600'(r_suffix) << {r_cnt, 3'b0}) ^ (1600'(8'h80) << {r_rate_b - CW'(1), 3'b0});
  always_comb begin
    w_kdata = '0;
    w_src_masked = '0;
    for (int j = 0; j < KEEP_W; j++) begin
      w_kdata[8*j +: 8] = w_src_data[8*j +: 8] & {8{w_src_keep[j]}};
      w_src_masked[8*j +: 8] = w_kdata[8*j +: 8] & {8{CW'(j) < w_room}};
    end
  end
  always_comb begin
    w_fsm_nx = r_fsm;
    case (r_fsm)
      S_IDLE, S_DONE: w_fsm_nx = start_i ? S_ABSORB : r_fsm;
      S_ABSORB:       if (w_beat) w_fsm_nx = w_fill ? S_PERM_REQ : t_last_i ? S_PAD : S_ABSORB;
      S_PERM_REQ:     w_fsm_nx = S_PERM_WAIT;
      S_PERM_WAIT:    if (perm_done_i) w_fsm_nx = r_carry_pend ? S_CARRY : r_pad_pend ? S_PAD : r_padded ? S_DONE : S_ABSORB;
      S_CARRY:        w_fsm_nx = w_fill ? S_PERM_REQ : r_pad_pend ? S_PAD : S_ABSORB;
      S_PAD:          w_fsm_nx = S_PERM_REQ;
      default:        w_fsm_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= S_IDLE;
      r_state <= '0;
      r_cnt <= '0;
      r_rate_b <= '0;
      r_suffix <= '0;
      r_carry_data <= '0;
      r_carry_keep <= '0;
      r_carry_pend <= 1'b0;
      r_pad_pend <= 1'b0;
      r_padded <= 1'b0;
    end else begin
      r_fsm <= w_fsm_nx;
      case (r_fsm)
        S_IDLE, S_DONE: if (start_i) begin
          r_state <= '0;
          r_cnt <= '0;
          r_rate_b <= CW'(rate_i >> 3);
          r_suffix <= suffix_i;
          r_carry_pend <= 1'b0;
          r_pad_pend <= 1'b0;
          r_padded <= 1'b0;
        end
        S_ABSORB, S_CARRY: if (w_beat || r_fsm == S_CARRY) begin
          r_state <= r_state ^ w_ins;
          r_cnt <= w_fill ? '0 : r_cnt + CW'(w_n);
          r_carry_pend <= w_fill && (CW'(w_n) > w_room);
          r_carry_data <= w_kdata >> {w_room, 3'b0};
          r_carry_keep <= w_src_keep >> w_room;
          if (r_fsm == S_ABSORB) r_pad_pend <= t_last_i;
        end
        S_PERM_WAIT: if (perm_done_i) r_state <= perm_state_i;
        S_PAD: begin
          r_state <= r_state ^ w_pad;
          r_pad_pend <= 1'b0;
          r_padded <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
